// File: rtl/spi_pkg.sv
// Shared SPI link definitions: frame width, transmitter FSM states and the
// debug view exported by the peripheral transmitter.
package spi_pkg;

    localparam int SPI_FRAME_W = 40;
    localparam int SPI_CNT_W   = $clog2(SPI_FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_tx_state_e;

    // Internal view of the transmitter, brought out for checkers.
    typedef struct packed {
        spi_tx_state_e          state;
        logic [SPI_CNT_W-1:0]   bit_cnt;
        logic                   hold_full;
        logic                   sclk_rise;
    } spi_tx_dbg_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle rise
// and fall pulses taken from the last two synchronized samples.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the line's idle level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral_tx.sv
// SPI peripheral transmitter: one-entry holding register, MSB-first shift-out
// on MISO, advanced by the master's SCLK falling edges while SS is low.
module spi_peripheral_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_FRAME_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              SCLK,
    input  logic              SS,
    output logic              MISO,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              underrun,
    output spi_tx_dbg_t       dbg
);

    // Handshake: a word moves when tx_valid && tx_ready are both high on a
    // rising clk edge; tx_ready is simply "holding register empty".

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_tx_state_e     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc, cnt_eff;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ur_q, ur_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ur_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ur_q        <= ur_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        last_d      = last_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ur_d        = 1'b0;
        cnt_inc     = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        cnt_eff     = sclk_fall ? cnt_inc : cnt_q;

        if (tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    // A word arriving in this very cycle waits for the next frame.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        last_d      = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d = last_q;
                        ur_d    = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    cnt_d   = cnt_eff;
                    shift_d = '0;
                    state_d = IDLE;
                    if (cnt_eff == CNT_LAST) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Zeros shift in, so MISO drops to 0 after the last bit.
                    cnt_d   = cnt_inc;
                    shift_d = {shift_q[DATA_W-2:0], 1'b0};
                    if (cnt_inc == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (ss_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
            end
        endcase
    end

    assign MISO       = shift_q[DATA_W-1];
    assign tx_ready   = !hold_full_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign underrun   = ur_q;

    assign dbg.state     = state_q;
    assign dbg.bit_cnt   = SPI_CNT_W'(cnt_q);
    assign dbg.hold_full = hold_full_q;
    assign dbg.sclk_rise = sclk_rise;

    a_pulse_excl: assert property (@(posedge clk) disable iff (!rst)
        !(frame_done && frame_err));
    a_cnt_sat: assert property (@(posedge clk) disable iff (!rst)
        cnt_q <= CNT_LAST);
    a_done_quiet: assert property (@(posedge clk) disable iff (!rst)
        (state_q == DONE) |-> !MISO);
    a_idle_quiet: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE) |-> !MISO);

endmodule
